// File: rtl/comp_sweep_driver_if.sv
// Bus between the comparator sweep driver and the comparator under test.
// The master side is the driver; the slave side is the comparator plus
// whoever issues start and reads back the sweep status.
interface comp_sweep_driver_if #(
  parameter int W = 2
);

  // Sweep control
  logic             start;

  // Operands towards the comparator
  logic [W-1:0]     P_out;
  logic [W-1:0]     Q_out;

  // Comparator results
  logic             G_in;
  logic             L_in;
  logic             E_in;

  // Sweep status
  logic             busy;
  logic             done;
  logic             pass;
  logic [2*W:0]     err_count;
  logic             fail_seen;
  logic [W-1:0]     fail_P;
  logic [W-1:0]     fail_Q;

  modport master (
    input  start,
    input  G_in,
    input  L_in,
    input  E_in,
    output P_out,
    output Q_out,
    output busy,
    output done,
    output pass,
    output err_count,
    output fail_seen,
    output fail_P,
    output fail_Q
  );

  modport slave (
    output start,
    output G_in,
    output L_in,
    output E_in,
    input  P_out,
    input  Q_out,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  fail_seen,
    input  fail_P,
    input  fail_Q
  );

endinterface

// File: rtl/comp_sweep_driver.sv
// Comparator sweep driver.
// Walks every (P,Q) operand pair through an external W-bit magnitude
// comparator, holds each pair SETTLE cycles, samples G/L/E on the last
// cycle of the hold and checks them against the unsigned P>Q / P<Q / P==Q.
// Reports the mismatch count, an overall pass flag and the first failing
// operand pair. All status outputs come straight from registers.
module comp_sweep_driver #(
  parameter int W      = 2,
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  comp_sweep_driver_if.master bus
);

  localparam int IW = 2 * W;                            // vector index width
  localparam int EW = 2 * W + 1;                        // error counter width
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1; // settle counter width

  localparam logic [IW-1:0] LAST_IDX    = {IW{1'b1}};
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Reference result for one operand pair, packed as {G, L, E}.
  function automatic logic [2:0] expected_flags(input logic [W-1:0] p,
                                                input logic [W-1:0] q);
    logic [2:0] flags;
    flags[2] = (p > q);
    flags[1] = (p < q);
    flags[0] = (p == q);
    return flags;
  endfunction

  // Registered state
  state_t          state_r;
  logic [IW-1:0]   index_r;
  logic [CW-1:0]   settle_r;
  logic            busy_r;
  logic            done_r;
  logic            pass_r;
  logic [EW-1:0]   err_count_r;
  logic            fail_seen_r;
  logic [W-1:0]    fail_p_r;
  logic [W-1:0]    fail_q_r;

  // Next-state values
  state_t          state_s;
  logic [IW-1:0]   index_s;
  logic [CW-1:0]   settle_s;
  logic            busy_s;
  logic            done_s;
  logic            pass_s;
  logic [EW-1:0]   err_count_s;
  logic            fail_seen_s;
  logic [W-1:0]    fail_p_s;
  logic [W-1:0]    fail_q_s;

  // Helpers for the sampling edge
  logic [W-1:0]    cur_p_s;
  logic [W-1:0]    cur_q_s;
  logic            mismatch_s;
  logic [EW-1:0]   err_upd_s;

  assign cur_p_s = index_r[IW-1:W];
  assign cur_q_s = index_r[W-1:0];

  // Next-state and datapath decisions for the sweep FSM.
  always_comb begin
    state_s     = state_r;
    index_s     = index_r;
    settle_s    = settle_r;
    busy_s      = busy_r;
    done_s      = done_r;
    pass_s      = pass_r;
    err_count_s = err_count_r;
    fail_seen_s = fail_seen_r;
    fail_p_s    = fail_p_r;
    fail_q_s    = fail_q_r;
    mismatch_s  = 1'b0;
    err_upd_s   = err_count_r;

    case (state_r)
      ST_IDLE, ST_DONE: begin
        // Idle and done both accept a new sweep; every result is cleared
        // so the new run reports only its own mismatches.
        if (bus.start) begin
          state_s     = ST_RUN;
          index_s     = {IW{1'b0}};
          settle_s    = {CW{1'b0}};
          busy_s      = 1'b1;
          done_s      = 1'b0;
          pass_s      = 1'b0;
          err_count_s = {EW{1'b0}};
          fail_seen_s = 1'b0;
          fail_p_s    = {W{1'b0}};
          fail_q_s    = {W{1'b0}};
        end else begin
          state_s = state_r;
        end
      end

      ST_RUN: begin
        // start is deliberately ignored here so a held start cannot
        // restart a sweep in progress.
        if (settle_r == SETTLE_LAST) begin
          // Any bit off, including a non-one-hot result, is a mismatch.
          mismatch_s = ({bus.G_in, bus.L_in, bus.E_in} !=
                        expected_flags(cur_p_s, cur_q_s));
          if (mismatch_s) begin
            err_upd_s = err_count_r + EW'(1);
            if (!fail_seen_r) begin
              fail_seen_s = 1'b1;
              fail_p_s    = cur_p_s;
              fail_q_s    = cur_q_s;
            end else begin
              fail_seen_s = fail_seen_r;
            end
          end else begin
            err_upd_s = err_count_r;
          end
          err_count_s = err_upd_s;

          if (index_r != LAST_IDX) begin
            index_s  = index_r + IW'(1);
            settle_s = {CW{1'b0}};
          end else begin
            // Final vector: pass must already include its own result.
            state_s = ST_DONE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            pass_s  = (err_upd_s == {EW{1'b0}});
          end
        end else begin
          settle_s = settle_r + CW'(1);
        end
      end

      default: begin
        // Unreachable encoding: fall back to a quiet idle.
        state_s = ST_IDLE;
        busy_s  = 1'b0;
        done_s  = 1'b0;
      end
    endcase
  end

  // FSM state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and status registers; reset clears every visible output.
  always_ff @(posedge clk) begin
    if (rst) begin
      index_r     <= {IW{1'b0}};
      settle_r    <= {CW{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      err_count_r <= {EW{1'b0}};
      fail_seen_r <= 1'b0;
      fail_p_r    <= {W{1'b0}};
      fail_q_r    <= {W{1'b0}};
    end else begin
      index_r     <= index_s;
      settle_r    <= settle_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      pass_r      <= pass_s;
      err_count_r <= err_count_s;
      fail_seen_r <= fail_seen_s;
      fail_p_r    <= fail_p_s;
      fail_q_r    <= fail_q_s;
    end
  end

  // Operands are the index halves: P is the upper half, Q the lower.
  assign bus.P_out     = index_r[IW-1:W];
  assign bus.Q_out     = index_r[W-1:0];
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.pass      = pass_r;
  assign bus.err_count = err_count_r;
  assign bus.fail_seen = fail_seen_r;
  assign bus.fail_P    = fail_p_r;
  assign bus.fail_Q    = fail_q_r;

endmodule

// File: tb/tb_comp_sweep_driver.sv
// Bench for comp_sweep_driver: a SETTLE=1 instance driven by a comparator
// model with selectable faults, and a SETTLE=3 instance with a golden
// comparator for hold-time and held-start checks.
module tb_comp_sweep_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  comp_sweep_driver_if #(.W(2)) if1 ();
  comp_sweep_driver_if #(.W(2)) if3 ();

  comp_sweep_driver #(.W(2), .SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.master));
  comp_sweep_driver #(.W(2), .SETTLE(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.master));

  int n_chk  = 0;
  int n_fail = 0;

  // Comparator fault modes: 0 golden, 1 G stuck 0, 2 L/E swapped, 3 random masks
  int         mode1 = 0;
  logic [2:0] rmask [16];

  typedef struct {
    int         mode;
    int         exp_err;
    bit         exp_pass;
    bit         exp_fs;
    logic [1:0] exp_fp;
    logic [1:0] exp_fq;
  } vec_t;

  vec_t tbl [3];

  function automatic logic [2:0] comp_model(input int mode, input logic [1:0] p, input logic [1:0] q);
    logic [2:0] t;
    t = {p > q, p < q, p == q};
    case (mode)
      0:       return t;
      1:       return {1'b0, t[1], t[0]};
      2:       return {t[2], t[0], t[1]};
      3:       return t ^ rmask[{p, q}];
      default: return t;
    endcase
  endfunction

  // Comparator outputs change away from the sampling edge.
  always @(negedge clk) begin
    {if1.G_in, if1.L_in, if1.E_in} = comp_model(mode1, if1.P_out, if1.Q_out);
    {if3.G_in, if3.L_in, if3.E_in} = comp_model(0, if3.P_out, if3.Q_out);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected sweep result from the comparison rules over all operand pairs.
  task automatic ref_sweep(input int mode, output int e, output bit fs,
                           output logic [1:0] fp, output logic [1:0] fq);
    e = 0; fs = 1'b0; fp = 2'b00; fq = 2'b00;
    for (int p = 0; p < 4; p++) begin
      for (int q = 0; q < 4; q++) begin
        logic [2:0] want;
        logic [2:0] got;
        want = {1'(p > q), 1'(p < q), 1'(p == q)};
        got  = comp_model(mode, 2'(p), 2'(q));
        if (got != want) begin
          e++;
          if (!fs) begin
            fs = 1'b1; fp = 2'(p); fq = 2'(q);
          end
        end
      end
    end
  endtask

  // Pulse start on instance 1; returns at the negedge after the start edge.
  task automatic start1();
    @(negedge clk); if1.start = 1'b1;
    @(negedge clk); if1.start = 1'b0;
  endtask

  task automatic wait_done1(input string nm, input int exp_lat);
    int c;
    c = 0;
    while (!if1.done && c < 400) begin
      @(negedge clk); c++;
    end
    chk({nm, " latency"}, 32'(c), 32'(exp_lat));
  endtask

  task automatic check_result1(input string nm, input int e, input bit ps, input bit fs,
                               input logic [1:0] fp, input logic [1:0] fq);
    chk({nm, " err_count"}, 32'(if1.err_count), 32'(e));
    chk({nm, " pass"},      32'(if1.pass),      32'(ps));
    chk({nm, " fail_seen"}, 32'(if1.fail_seen), 32'(fs));
    chk({nm, " busy"},      32'(if1.busy),      32'(0));
    if (fs) begin
      chk({nm, " fail_P"}, 32'(if1.fail_P), 32'(fp));
      chk({nm, " fail_Q"}, 32'(if1.fail_Q), 32'(fq));
    end else begin
      chk({nm, " fail_PQ"}, 32'({if1.fail_P, if1.fail_Q}), 32'(0));
    end
  endtask

  task automatic check_zero1(input string nm);
    chk({nm, " PQ"},        32'({if1.P_out, if1.Q_out}), 32'(0));
    chk({nm, " flags"},     32'({if1.busy, if1.done, if1.pass, if1.fail_seen}), 32'(0));
    chk({nm, " err_count"}, 32'(if1.err_count), 32'(0));
    chk({nm, " fail_PQ"},   32'({if1.fail_P, if1.fail_Q}), 32'(0));
  endtask

  initial begin
    int         e;
    bit         fs;
    logic [1:0] fp;
    logic [1:0] fq;

    tbl[0] = '{0, 0,  1'b1, 1'b0, 2'b00, 2'b00};
    tbl[1] = '{1, 6,  1'b0, 1'b1, 2'b01, 2'b00};
    tbl[2] = '{2, 10, 1'b0, 1'b1, 2'b00, 2'b00};
    for (int i = 0; i < 16; i++) rmask[i] = 3'b000;
    if1.start = 1'b0;
    if3.start = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero1("reset");
    chk("reset dut3", 32'({if3.busy, if3.done, if3.err_count, if3.P_out, if3.Q_out}), 32'(0));
    rst = 1'b0;

    // Table-driven sweeps with fixed comparator faults
    for (int i = 0; i < 3; i++) begin
      mode1 = tbl[i].mode;
      start1();
      chk("run busy", 32'(if1.busy), 32'(1));
      wait_done1("table", 16);
      check_result1("table", tbl[i].exp_err, tbl[i].exp_pass, tbl[i].exp_fs,
                    tbl[i].exp_fp, tbl[i].exp_fq);
    end

    // Restart from DONE after a failing sweep with a golden comparator
    mode1 = 0;
    start1();
    chk("restart err_count", 32'(if1.err_count), 32'(0));
    chk("restart fail_seen", 32'(if1.fail_seen), 32'(0));
    chk("restart done",      32'(if1.done),      32'(0));
    chk("restart busy",      32'(if1.busy),      32'(1));
    wait_done1("restart", 16);
    check_result1("restart", 0, 1'b1, 1'b0, 2'b00, 2'b00);

    // Random comparator faults checked against the reference model
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++)
        rmask[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      mode1 = 3;
      ref_sweep(3, e, fs, fp, fq);
      start1();
      wait_done1("random", 16);
      check_result1("random", e, (e == 0), fs, fp, fq);
    end
    mode1 = 0;

    // SETTLE=3 with start held throughout the run
    @(negedge clk); if3.start = 1'b1;
    for (int n = 0; n < 48; n++) begin
      @(negedge clk);
      chk("hold index", 32'({if3.P_out, if3.Q_out}), 32'(n / 3));
      chk("hold busy",  32'({if3.busy, if3.done}), 32'(2));
    end
    @(negedge clk);
    if3.start = 1'b0;
    chk("settle3 done", 32'({if3.busy, if3.done}), 32'(1));
    chk("settle3 pass", 32'(if3.pass), 32'(1));
    chk("settle3 err",  32'(if3.err_count), 32'(0));

    // Reset in the middle of a sweep
    start1();
    repeat (7) @(negedge clk);
    chk("mid index", 32'({if1.P_out, if1.Q_out}), 32'(7));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero1("mid reset");
    start1();
    chk("post-reset PQ",   32'({if1.P_out, if1.Q_out}), 32'(0));
    chk("post-reset busy", 32'(if1.busy), 32'(1));
    wait_done1("post-reset", 16);
    check_result1("post-reset", 0, 1'b1, 1'b0, 2'b00, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
